// File: rtl/trace_tx.sv
// rtl/trace_tx.sv - execution trace capture FIFO with 4-beat word serializer
module trace_tx #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_reg_write,
    input  logic [3:0]  wb_reg_sel,
    input  logic [15:0] wb_reg_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        hlt,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_done,
    output logic        ovf,
    output logic [15:0] inst_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {STREAM = 1'b0, DONE = 1'b1} state_t;

    state_t      state;
    state_t      state_nx;
    logic [63:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [1:0]  beat;
    logic        halted;
    logic [63:0] head;
    logic [63:0] rec;
    logic [15:0] mdata;
    logic        empty;
    logic        full;
    logic        ev;
    logic        counted;
    logic        accept;
    logic        pop;
    logic        push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign ev      = !halted && (wb_reg_write || mem_read || mem_write || hlt);
    assign counted = ev && (hlt || wb_reg_write || mem_write);
    assign accept  = tx_valid && tx_ready;
    assign pop     = accept && (beat == 2'd3);
    // A pop on the same edge frees the slot, so a full FIFO can still take the push.
    assign push    = ev && (!full || pop);

    // Assemble the 64-bit record; unused fields are forced to zero.
    always_comb begin
        mdata = 16'h0000;
        if (mem_read) begin
            mdata = mem_rdata;
        end else if (mem_write) begin
            mdata = mem_wdata;
        end
        rec = {hlt, mem_write, mem_read, wb_reg_write,
               wb_reg_write ? wb_reg_sel : 4'h0,
               inst_count[7:0],
               wb_reg_write ? wb_reg_data : 16'h0000,
               (mem_read || mem_write) ? mem_addr : 16'h0000,
               mdata};
    end

    // Record storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr[AW-1:0]] <= rec;
        end
    end

    // Pointers, beat counter, event counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat       <= 2'd0;
            inst_count <= 16'h0000;
            halted     <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ev && !push) begin
                ovf <= 1'b1;
            end
            if (accept) begin
                beat <= beat + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (counted) begin
                inst_count <= inst_count + 16'd1;
            end
            if (ev && hlt) begin
                halted <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STREAM;
        end else begin
            state <= state_nx;
        end
    end

    // Finish after the halt record's last beat, or once drained if that record was dropped.
    always_comb begin
        state_nx = state;
        case (state)
            STREAM: begin
                if ((pop && head[63]) || (halted && empty)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = STREAM;
        endcase
    end

    // Output decode: beat selects one 16-bit slice of the head record.
    always_comb begin
        tx_valid = (state == STREAM) && !empty;
        tx_done  = (state == DONE);
        tx_data  = 16'h0000;
        if (tx_valid) begin
            case (beat)
                2'd0:    tx_data = head[63:48];
                2'd1:    tx_data = head[47:32];
                2'd2:    tx_data = head[31:16];
                default: tx_data = head[15:0];
            endcase
        end
    end

endmodule

// File: tb/tb_trace_tx.sv
// tb/tb_trace_tx.sv - self-checking bench for trace_tx
module tb_trace_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write;
    logic [3:0]  wb_reg_sel;
    logic [15:0] wb_reg_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        hlt;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_done;
    logic        ovf;
    logic [15:0] inst_count;

    trace_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_reg_sel(wb_reg_sel), .wb_reg_data(wb_reg_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_done(tx_done), .ovf(ovf), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queue of whole records plus the beat index into the head.
    logic [63:0] q[$];
    int          m_beat;
    logic [15:0] m_cnt;
    bit          m_halted, m_ovf, m_done;
    logic [15:0] got[$];

    typedef struct {
        logic        wb;
        logic [3:0]  sel;
        logic [15:0] wd;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [63:0] mk_rec(logic wb, logic [3:0] sel, logic [15:0] wd,
                                           logic mr, logic mw, logic [15:0] addr,
                                           logic [15:0] wdat, logic [15:0] rdat,
                                           logic h, logic [7:0] seq);
        logic [15:0] md;
        md = mr ? rdat : (mw ? wdat : 16'h0000);
        return {h, mw, mr, wb, wb ? sel : 4'h0, seq, wb ? wd : 16'h0000,
                (mr || mw) ? addr : 16'h0000, md};
    endfunction

    function automatic logic [15:0] word_of(logic [63:0] r, int b);
        return r[63 - 16*b -: 16];
    endfunction

    task automatic model_reset();
        q.delete();
        m_beat = 0; m_cnt = 16'h0; m_halted = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        wb_reg_write = 0; wb_reg_sel = 0; wb_reg_data = 0;
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
        hlt = 0;
    endtask

    // One clock: compare against the model at negedge, then advance the model.
    task automatic step();
        bit          mv, accept, pop, ndone, ev;
        logic [15:0] md;
        @(negedge clk);
        mv = (q.size() > 0) && !m_done;
        md = mv ? word_of(q[0], m_beat) : 16'h0000;
        vectors++;
        if (tx_valid !== mv || tx_data !== md || tx_done !== m_done ||
            ovf !== m_ovf || inst_count !== m_cnt) begin
            miscompares++;
            $display("FAIL model: dut v=%b d=%h done=%b ovf=%b cnt=%h exp v=%b d=%h done=%b ovf=%b cnt=%h",
                     tx_valid, tx_data, tx_done, ovf, inst_count, mv, md, m_done, m_ovf, m_cnt);
        end
        if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
        if (!rst_n) begin
            model_reset();
        end else begin
            accept = mv && tx_ready;
            pop    = accept && (m_beat == 3);
            ndone  = m_done;
            if (!m_done) begin
                if (pop && q[0][63]) ndone = 1;
                else if (m_halted && q.size() == 0) ndone = 1;
            end
            ev = !m_halted && (wb_reg_write || mem_read || mem_write || hlt);
            if (accept) m_beat = (m_beat + 1) % 4;
            if (pop) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH)
                    q.push_back(mk_rec(wb_reg_write, wb_reg_sel, wb_reg_data, mem_read, mem_write,
                                       mem_addr, mem_wdata, mem_rdata, hlt, m_cnt[7:0]));
                else
                    m_ovf = 1;
                if (hlt || wb_reg_write || mem_write) m_cnt = m_cnt + 16'd1;
                if (hlt) m_halted = 1;
            end
            m_done = ndone;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        step();
        rst_n = 1;
        got.delete();
    endtask

    task automatic reg_write(logic [3:0] sel, logic [15:0] d);
        set_idle();
        wb_reg_write = 1; wb_reg_sel = sel; wb_reg_data = d;
        step();
        set_idle();
    endtask

    initial begin
        set_idle();
        tx_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;

        // Reset state
        chk("reset_valid", {15'h0, tx_valid}, 16'h0);
        chk("reset_data", tx_data, 16'h0);
        chk("reset_cnt", inst_count, 16'h0);

        // Single register write r3=0x1234, table-driven cycle by cycle
        tbl[0] = '{1'b1, 4'h3, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'd0};
        tbl[1] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 16'h1300, 16'd1};
        tbl[2] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'd1};
        tbl[3] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'd1};
        tbl[4] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'd1};
        tbl[5] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'd1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            wb_reg_write = tbl[i].wb; wb_reg_sel = tbl[i].sel; wb_reg_data = tbl[i].wd;
            tx_ready = tbl[i].rdy;
            chk($sformatf("tbl%0d_valid", i), {15'h0, tx_valid}, {15'h0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_cnt", i), inst_count, tbl[i].exp_cnt);
            step();
        end

        // Register write plus store in the same cycle
        do_reset();
        tx_ready = 1;
        set_idle();
        wb_reg_write = 1; wb_reg_sel = 4'h1; wb_reg_data = 16'h00AA;
        mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF;
        step();
        set_idle();
        repeat (6) step();
        chk("combo_n", 16'(got.size()), 16'd4);
        chk("combo_b0", got[0], 16'h5100);
        chk("combo_b1", got[1], 16'h00AA);
        chk("combo_b2", got[2], 16'h0040);
        chk("combo_b3", got[3], 16'hBEEF);

        // Backpressure held across beat2
        do_reset();
        tx_ready = 1;
        set_idle();
        wb_reg_write = 1; wb_reg_sel = 4'h4; wb_reg_data = 16'hCAFE;
        mem_write = 1; mem_addr = 16'h0200; mem_wdata = 16'h7777;
        step();
        set_idle();
        repeat (2) step();
        tx_ready = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_data", tx_data, 16'h0200);
        end
        tx_ready = 1;
        repeat (4) step();
        chk("stall_n", 16'(got.size()), 16'd4);
        chk("stall_b2", got[2], 16'h0200);
        chk("stall_b3", got[3], 16'h7777);

        // Overflow: nine writes into an eight-deep FIFO
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 9; i++) reg_write(4'h2, 16'(i));
        chk("ovf_flag", {15'h0, ovf}, 16'h1);
        chk("ovf_cnt", inst_count, 16'd9);
        tx_ready = 1;
        repeat (40) step();
        chk("ovf_n", 16'(got.size()), 16'd32);
        for (int i = 0; i < 8; i++) chk("ovf_seq", got[4*i], 16'h1200 | 16'(i));

        // Load, halt, then an ignored write
        do_reset();
        tx_ready = 1;
        set_idle();
        mem_read = 1; mem_addr = 16'h0010; mem_rdata = 16'h5555;
        step();
        set_idle(); hlt = 1;
        step();
        reg_write(4'h7, 16'h9999);
        repeat (12) step();
        chk("halt_n", 16'(got.size()), 16'd8);
        chk("halt_load_b0", got[0], 16'h2000);
        chk("halt_load_b3", got[3], 16'h5555);
        chk("halt_b0", got[4], 16'h8000);
        chk("halt_cnt", inst_count, 16'd1);
        chk("halt_done", {15'h0, tx_done}, 16'h1);

        // Halt record dropped by a full FIFO still ends the stream
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 8; i++) reg_write(4'h1, 16'(i));
        set_idle(); hlt = 1;
        step();
        set_idle();
        chk("drop_halt_ovf", {15'h0, ovf}, 16'h1);
        tx_ready = 1;
        repeat (40) step();
        chk("drop_halt_done", {15'h0, tx_done}, 16'h1);

        // Reset during beat1
        do_reset();
        tx_ready = 1;
        reg_write(4'h5, 16'h0101);
        step();
        set_idle(); wb_reg_write = 1; wb_reg_sel = 4'h9;
        rst_n = 0;
        step();
        rst_n = 1;
        set_idle();
        chk("rst_valid", {15'h0, tx_valid}, 16'h0);
        chk("rst_data", tx_data, 16'h0);
        chk("rst_cnt", inst_count, 16'h0);
        chk("rst_ovf", {15'h0, ovf}, 16'h0);
        reg_write(4'h6, 16'h0042);
        chk("rst_seq", tx_data, 16'h1600);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit stall;
            stall = ((i / 64) % 3) == 1;
            rst_n = ($urandom_range(0, 299) != 0) && !(m_done && $urandom_range(0, 9) == 0);
            wb_reg_write = $urandom_range(0, 2) == 0;
            wb_reg_sel   = 4'($urandom);
            wb_reg_data  = 16'($urandom);
            mem_read     = $urandom_range(0, 3) == 0;
            mem_write    = $urandom_range(0, 3) == 0;
            mem_addr     = 16'($urandom);
            mem_wdata    = 16'($urandom);
            mem_rdata    = 16'($urandom);
            hlt          = $urandom_range(0, 199) == 0;
            tx_ready     = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
